// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: multi-layer controller for the IMG2COL_GEMM core.
// Holds a descriptor table. On run it walks layers 0..num_layers-1. For each
// layer it loads the core configuration, pulses core_start, waits for the core,
// and flips the ping-pong bank.
// Optional watchdog: define SEQ_TIMEOUT_EN to enable the per-wait-state timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for run
// LOAD      | copy table[layer_idx] into the core field registers
// START     | core_start is registered high on leaving this state
// WAIT_PARA | waiting for core_para_done
// WAIT_DONE | waiting for core_w_done
// SWAP      | toggle bank_sel, advance or finish
// FINISH    | done pulse
// ERROR     | watchdog expiry, set err, back to IDLE

`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 2
`endif
`ifndef KERNEL_NUMS_SIZE
`define KERNEL_NUMS_SIZE 8
`endif
`ifndef SHIFT_WIDTH
`define SHIFT_WIDTH 5
`endif

module conv_layer_sequencer #(
   parameter int MAX_LAYERS     = 8,
   parameter int LIDX_W         = $clog2(MAX_LAYERS),
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int DESC_W         = `TENSOR_SIZE + `KERNEL_SIZE + `CHANNELS_SIZE +
                                  `STRIDE_SIZE + `KERNEL_NUMS_SIZE + `SHIFT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_we,
   input  logic [LIDX_W-1:0]             cfg_addr,
   input  logic [DESC_W-1:0]             cfg_wdata,
   input  logic [LIDX_W:0]               num_layers,
   input  logic                          run,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [LIDX_W-1:0]             layer_idx,
   output logic                          bank_sel,
   output logic                          core_start,
   output logic [`TENSOR_SIZE-1:0]       core_tensor_size,
   output logic [`KERNEL_SIZE-1:0]       core_kernel_size,
   output logic [`CHANNELS_SIZE-1:0]     core_channels,
   output logic [`STRIDE_SIZE-1:0]       core_stride,
   output logic [`KERNEL_NUMS_SIZE-1:0]  core_kernel_nums,
   output logic [`SHIFT_WIDTH-1:0]       core_shift,
   input  logic                          core_para_done,
   input  logic                          core_w_done
);

   localparam int KS_LSB = `TENSOR_SIZE;
   localparam int CH_LSB = KS_LSB + `KERNEL_SIZE;
   localparam int ST_LSB = CH_LSB + `CHANNELS_SIZE;
   localparam int KN_LSB = ST_LSB + `STRIDE_SIZE;
   localparam int SH_LSB = KN_LSB + `KERNEL_NUMS_SIZE;
   localparam logic [LIDX_W:0] MAX_CNT = (LIDX_W+1)'(MAX_LAYERS);

   typedef enum logic [2:0] {
      IDLE, LOAD, START, WAIT_PARA, WAIT_DONE, SWAP, FINISH, ERROR
   } state_t;

   state_t            state, state_nxt;
   logic [DESC_W-1:0] desc_tbl [MAX_LAYERS];
   logic [LIDX_W:0]   layer_cnt;
   logic              last_layer;

   assign last_layer = ({1'b0, layer_idx} == (layer_cnt - 1'b1));
   assign done       = (state == FINISH);

`ifdef SEQ_TIMEOUT_EN
   logic [31:0] wdog;
   logic        wdog_exp;

   assign wdog_exp = (wdog == 32'(TIMEOUT_CYCLES - 1));

   // watchdog: restarts on every state change, counts cycles spent waiting
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wdog <= '0;
      else if (state_nxt != state)
         wdog <= '0;
      else if (state == WAIT_PARA || state == WAIT_DONE)
         wdog <= wdog + 32'd1;
   end
`endif

   // descriptor table: no reset, writes are dropped while a sequence runs
   always_ff @(posedge clk) begin
      if (cfg_we && !busy)
         desc_tbl[cfg_addr] <= cfg_wdata;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (run && num_layers <= MAX_CNT)
               state_nxt = (num_layers == '0) ? FINISH : LOAD;
         end
         LOAD:      state_nxt = START;
         START:     state_nxt = WAIT_PARA;
         WAIT_PARA: begin
            if (core_para_done)
               state_nxt = WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
            else if (wdog_exp)
               state_nxt = ERROR;
`endif
         end
         WAIT_DONE: begin
            if (core_w_done)
               state_nxt = SWAP;
`ifdef SEQ_TIMEOUT_EN
            else if (wdog_exp)
               state_nxt = ERROR;
`endif
         end
         SWAP:      state_nxt = last_layer ? FINISH : LOAD;
         FINISH:    state_nxt = IDLE;
         ERROR:     state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // sequencing datapath: status flags, layer counter, bank select, core fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy             <= 1'b0;
         err              <= 1'b0;
         layer_idx        <= '0;
         layer_cnt        <= '0;
         bank_sel         <= 1'b0;
         core_start       <= 1'b0;
         core_tensor_size <= '0;
         core_kernel_size <= '0;
         core_channels    <= '0;
         core_stride      <= '0;
         core_kernel_nums <= '0;
         core_shift       <= '0;
      end else begin
         core_start <= (state == START);
         case (state)
            IDLE: begin
               if (run) begin
                  if (num_layers > MAX_CNT) begin
                     err <= 1'b1;
                  end else if (num_layers != '0) begin
                     layer_cnt <= num_layers;
                     layer_idx <= '0;
                     bank_sel  <= 1'b0;
                     err       <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            end
            LOAD: begin
               core_tensor_size <= desc_tbl[layer_idx][KS_LSB-1:0];
               core_kernel_size <= desc_tbl[layer_idx][CH_LSB-1:KS_LSB];
               core_channels    <= desc_tbl[layer_idx][ST_LSB-1:CH_LSB];
               core_stride      <= desc_tbl[layer_idx][KN_LSB-1:ST_LSB];
               core_kernel_nums <= desc_tbl[layer_idx][SH_LSB-1:KN_LSB];
               core_shift       <= desc_tbl[layer_idx][DESC_W-1:SH_LSB];
            end
            WAIT_PARA, WAIT_DONE: begin
               if (state_nxt == ERROR)
                  busy <= 1'b0;
            end
            SWAP: begin
               bank_sel <= ~bank_sel;
               if (last_layer)
                  busy <= 1'b0;
               else
                  layer_idx <= layer_idx + 1'b1;
            end
            ERROR:   err <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Multi-layer controller placed in front of the IMG2COL_GEMM convolution core. It holds a small table of per-layer descriptors, programmed through a write port. When it receives a `run` pulse, it executes layers `0 .. num_layers-1` back to back. For each layer it drives the core's static configuration inputs and pulses the core's `start`. It then waits for the core's `para_done` and `w_done`, and toggles a ping-pong bank select so that each layer's output memory becomes the next layer's input.

## Interface
Parameters:
- `MAX_LAYERS`, 8: descriptor table depth.
- `LIDX_W`, `$clog2(MAX_LAYERS)`: layer index width.
- `TIMEOUT_CYCLES`, 1048576: watchdog limit per wait state. Used only with `SEQ_TIMEOUT_EN`.
- `DESC_W`, `` `TENSOR_SIZE+`KERNEL_SIZE+`CHANNELS_SIZE+`STRIDE_SIZE+`KERNEL_NUMS_SIZE+`SHIFT_WIDTH ``: descriptor width.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst`, in, 1: asynchronous reset, active-high.
- `cfg_we`, in, 1: descriptor write strobe.
- `cfg_addr`, in, `LIDX_W`: descriptor slot to write.
- `cfg_wdata`, in, `DESC_W`: descriptor packed LSB→MSB as {tensor_size, kernel_size, channels, stride, kernel_nums, shift}.
- `num_layers`, in, `LIDX_W+1`: layer count, sampled on an accepted `run`.
- `run`, in, 1: start pulse. Honoured only in IDLE.
- `busy`, out, 1: high from acceptance of `run` through the last SWAP.
- `done`, out, 1: one-cycle pulse when a sequence completes.
- `err`, out, 1: sticky error flag.
- `layer_idx`, out, `LIDX_W`: index of the layer currently executing.
- `bank_sel`, out, 1: ping-pong bank select. 0 means tensors are read from bank A and results written to bank B; 1 is the reverse.
- `core_start`, out, 1: one-cycle start pulse to the core.
- `core_tensor_size`, `core_kernel_size`, `core_channels`, `core_stride`, `core_kernel_nums`, `core_shift`, out, widths as in config.v: registered layer fields.
- `core_para_done`, in, 1: core parameter preparation finished (level).
- `core_w_done`, in, 1: core result write finished (pulse).

## Operation
- Descriptor table: `MAX_LAYERS` × `DESC_W` register array.
  - Written on `cfg_we` only when `busy`=0. Writes while busy are dropped.
  - Not cleared by reset.
- FSM states: IDLE, LOAD, START, WAIT_PARA, WAIT_DONE, SWAP, FINISH, ERROR.
- IDLE + `run`:
  - If `num_layers`>`MAX_LAYERS`: `err`←1, stay in IDLE.
  - If `num_layers`=0: go to FINISH.
  - Otherwise: latch the count, `layer_idx`←0, `bank_sel`←0, `err`←0, go to LOAD.
- LOAD: copy `table[layer_idx]` into the `core_*` field registers → START.
- START: `core_start`=1 for exactly one cycle → WAIT_PARA.
- WAIT_PARA: wait for `core_para_done`=1 → WAIT_DONE.
- WAIT_DONE: wait for `core_w_done`=1 → SWAP.
- SWAP: `bank_sel` toggles.
  - If `layer_idx`=count-1 → FINISH.
  - Otherwise `layer_idx`+1 → LOAD.
- FINISH: `done`=1 for one cycle → IDLE.
- ERROR (watchdog only): `err`←1 → IDLE. `done` is not pulsed.
- `core_*` field registers hold their value from LOAD until the next LOAD. They are stable for the core's whole run.
- Ignored events:
  - `run` while not in IDLE.
  - `core_w_done` outside WAIT_DONE.
  - `core_para_done` outside WAIT_PARA.
- If `core_para_done` and `core_w_done` are both high in WAIT_PARA, only the `core_para_done` transition is taken. `core_w_done` in that cycle is lost.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `layer_idx`=0, `bank_sel`=0, `core_start`=0, all `core_*` fields 0. FSM goes to IDLE.
- Reset asserted mid-sequence aborts immediately, with no `done` pulse.
- Accepting `run` at edge N:
  - `busy`=1 after edge N.
  - LOAD at edge N+1.
  - `core_start`=1 in the cycle after edge N+2.
- `core_w_done` sampled at edge M: SWAP in cycle M+1.
  - Next `core_start` two cycles after SWAP (LOAD, then START).
  - Or `done` in the cycle after SWAP.
- `busy` drops on the same edge that enters FINISH. `done` and `busy`=0 coincide.
- A new `run` is accepted in the cycle after `done`.
- Minimum gap between consecutive `core_start` pulses: 5 cycles.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A 32-bit watchdog counter clears on entry to WAIT_PARA and WAIT_DONE and increments each cycle spent in them.
  - Reaching `TIMEOUT_CYCLES` enters ERROR.
- `SEQ_TIMEOUT_EN` undefined:
  - No counter and no ERROR state.
  - The FSM waits indefinitely, and `err` is set only by an oversized `num_layers`.

## Test plan
- Program 3 layers, `num_layers`=3, `run`, core model responds → exactly 3 `core_start` pulses carrying fields of slots 0,1,2; `bank_sel` sequence 0→1→0→1; one `done`.
- `num_layers`=0, `run` → `done` 2 cycles later, no `core_start`, `busy` never high.
- `num_layers`=`MAX_LAYERS`+1 → `err`=1, no `core_start`. A following valid `run` clears `err`.
- `cfg_we` to slot 1 during layer 0 of a 2-layer run → layer 1 uses the old slot-1 value. `run` pulses while busy are ignored.
- `rst` asserted while in WAIT_DONE → all outputs return to reset values, no `done`. A new sequence then runs cleanly.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `core_w_done` withheld → `err`=1 and IDLE within 17 cycles of entering WAIT_DONE, with no `done` pulse.
